// File: rtl/water_level_conditioner.sv
// Decimating 4-sample averager for the raw water level ADC, with hysteretic full/empty flags and per-sample delta.
// Optional WATER_LEVEL_SPIKE_REJECT_EN drops isolated out-of-window samples once the average is valid.
module water_level_conditioner #(
    parameter int SAMPLE_DIV   = 5,
    parameter int FULL_HYST    = 8,
    parameter int EMPTY_THRESH = 20,
    parameter int EMPTY_HYST   = 8,
    parameter int SPIKE_MAX    = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [9:0]         i_water_level_sensor,
    input  logic [9:0]         i_target_level,
    output logic               o_sample_tick,
    output logic [9:0]         o_level_avg,
    output logic               o_level_valid,
    output logic               o_level_full,
    output logic               o_level_empty,
    output logic signed [10:0] o_level_delta,
    output logic [7:0]         o_spike_count
);

    logic [7:0]         r_presc;
    logic [9:0]         r_buf [4];
    logic [2:0]         r_cnt;
    logic [9:0]         r_avg;
    logic               r_valid;
    logic               r_full;
    logic               r_empty;
    logic signed [10:0] r_delta;

    logic               w_tick;
    logic               w_reject;
    logic               w_accept;
    logic [11:0]        w_sum;
    logic [9:0]         w_new_avg;
    logic [2:0]         w_cnt_next;
    logic               w_valid_next;
    logic [9:0]         w_full_floor;
    logic               w_full_next;
    logic               w_empty_next;
    logic signed [10:0] w_delta_next;

    assign w_tick    = (r_presc == 8'(SAMPLE_DIV - 1));
    // Oldest entry (r_buf[3]) drops out, so it is excluded from the new sum.
    assign w_sum     = 12'(i_water_level_sensor) + 12'(r_buf[0]) + 12'(r_buf[1]) + 12'(r_buf[2]);
    assign w_new_avg = w_sum[11:2];
    assign w_accept  = w_tick && !w_reject;

    assign w_cnt_next   = (r_cnt == 3'd4) ? 3'd4 : r_cnt + 3'd1;
    assign w_valid_next = (w_cnt_next == 3'd4);
    assign w_full_floor = (i_target_level >= 10'(FULL_HYST)) ? i_target_level - 10'(FULL_HYST) : 10'd0;

    always_comb begin
        w_full_next = r_full;
        if (w_new_avg >= i_target_level)
            w_full_next = 1'b1;
        else if (w_new_avg < w_full_floor)
            w_full_next = 1'b0;

        w_empty_next = r_empty;
        if (w_new_avg <= 10'(EMPTY_THRESH))
            w_empty_next = 1'b1;
        else if (w_new_avg > 10'(EMPTY_THRESH + EMPTY_HYST))
            w_empty_next = 1'b0;

        w_delta_next = 11'sd0;
        if (r_valid)
            w_delta_next = $signed({1'b0, w_new_avg}) - $signed({1'b0, r_avg});
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= 8'd0;
            r_buf   <= '{default: 10'd0};
            r_cnt   <= 3'd0;
            r_avg   <= 10'd0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b0;
            r_delta <= 11'sd0;
        end else begin
            r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
            if (w_accept) begin
                r_buf[0] <= i_water_level_sensor;
                r_buf[1] <= r_buf[0];
                r_buf[2] <= r_buf[1];
                r_buf[3] <= r_buf[2];
                r_cnt    <= w_cnt_next;
                if (w_valid_next) begin
                    r_valid <= 1'b1;
                    r_avg   <= w_new_avg;
                    r_delta <= w_delta_next;
                    r_full  <= w_full_next;
                    r_empty <= w_empty_next;
                end
            end
        end
    end

`ifdef WATER_LEVEL_SPIKE_REJECT_EN
    logic [7:0]         r_spk_cnt;
    logic [1:0]         r_spk_run;
    logic signed [10:0] w_diff;
    logic [10:0]        w_abs;

    assign w_diff   = $signed({1'b0, i_water_level_sensor}) - $signed({1'b0, r_avg});
    assign w_abs    = w_diff[10] ? 11'(-w_diff) : 11'(w_diff);
    // Two rejections in a row are tolerated; the third outlier is taken as a real step.
    assign w_reject = r_valid && (w_abs > 11'(SPIKE_MAX)) && (r_spk_run != 2'd2);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_spk_cnt <= 8'd0;
            r_spk_run <= 2'd0;
        end else if (w_tick) begin
            if (w_reject) begin
                r_spk_run <= r_spk_run + 2'd1;
                if (r_spk_cnt != 8'hFF)
                    r_spk_cnt <= r_spk_cnt + 8'd1;
            end else begin
                r_spk_run <= 2'd0;
            end
        end
    end

    assign o_spike_count = r_spk_cnt;
`else
    assign w_reject      = 1'b0;
    assign o_spike_count = 8'd0;
`endif

    assign o_sample_tick = w_tick;
    assign o_level_avg   = r_avg;
    assign o_level_valid = r_valid;
    assign o_level_full  = r_full;
    assign o_level_empty = r_empty;
    assign o_level_delta = r_delta;

endmodule

// File: tb/tb_water_level_conditioner.sv
// Directed bench for water_level_conditioner; spike expectations follow WATER_LEVEL_SPIKE_REJECT_EN.
module tb_water_level_conditioner;

    logic               clk;
    logic               reset;
    logic [9:0]         sensor;
    logic [9:0]         target;
    logic               tick;
    logic [9:0]         avg;
    logic               valid;
    logic               full;
    logic               empty;
    logic signed [10:0] delta;
    logic [7:0]         spikes;

    int n_tests = 0;
    int n_fail  = 0;

    water_level_conditioner dut (
        .i_clk                (clk),
        .i_reset              (reset),
        .i_water_level_sensor (sensor),
        .i_target_level       (target),
        .o_sample_tick        (tick),
        .o_level_avg          (avg),
        .o_level_valid        (valid),
        .o_level_full         (full),
        .o_level_empty        (empty),
        .o_level_delta        (delta),
        .o_spike_count        (spikes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench in cycle 1 after release (prescaler at 0), at a negedge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (bounded) for the next tick, then one more cycle so registered outputs reflect it.
    task automatic tick_update();
        int k;
        k = 0;
        while (tick !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (tick !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: no sample_tick within %0d cycles", k);
        end
        @(negedge clk);
    endtask

    task automatic fill(input logic [9:0] s, input logic [9:0] t);
        sensor = s;
        target = t;
        do_reset();
        repeat (4) tick_update();
    endtask

    task automatic test_reset();
        sensor = 10'd300;
        target = 10'd300;
        do_reset();
        n_tests++;
        if ({tick, avg, valid, full, empty, delta, spikes} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {tick, avg, valid, full, empty, delta, spikes});
        end
        for (int k = 1; k <= 5; k++) begin
            n_tests++;
            if (tick !== (k == 5)) begin
                n_fail++;
                $display("FAIL tick_cycle%0d: got %b required %b", k, tick, (k == 5));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fill_300();
        sensor = 10'd300;
        target = 10'd300;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick_update();
            n_tests++;
            if (valid !== 1'b0 || avg !== 10'd0 || full !== 1'b0 || delta !== 11'sd0) begin
                n_fail++;
                $display("FAIL prevalid_%0d: valid=%b avg=%0d full=%b delta=%0d required 0,0,0,0",
                         k, valid, avg, full, delta);
            end
        end
        tick_update();
        n_tests++;
        if (valid !== 1'b1 || avg !== 10'd300 || full !== 1'b1 || empty !== 1'b0 || delta !== 11'sd0) begin
            n_fail++;
            $display("FAIL fill_valid: valid=%b avg=%0d full=%b empty=%b delta=%0d required 1,300,1,0,0",
                     valid, avg, full, empty, delta);
        end
    endtask

    task automatic test_full_hyst();
        int ea[8];
        int ed[8];
        logic ef[8];
        ea = '{298, 297, 296, 295, 293, 292, 291, 290};
        ed = '{-2, -1, -1, -1, -2, -1, -1, -1};
        ef = '{1, 1, 1, 1, 1, 1, 0, 0};
        fill(10'd300, 10'd300);
        for (int k = 0; k < 8; k++) begin
            sensor = (k < 4) ? 10'd295 : 10'd290;
            tick_update();
            n_tests++;
            if (avg !== 10'(ea[k]) || delta !== 11'(ed[k]) || full !== ef[k]) begin
                n_fail++;
                $display("FAIL full_hyst_%0d: avg=%0d delta=%0d full=%b required %0d,%0d,%b",
                         k, avg, delta, full, ea[k], ed[k], ef[k]);
            end
        end
    endtask

    task automatic test_empty();
        int ea[8];
        logic ee[8];
        ea = '{6, 12, 18, 25, 28, 32, 36, 40};
        ee = '{1, 1, 1, 1, 1, 0, 0, 0};
        // target 0 forces full while valid, so both flags coexist at the bottom.
        fill(10'd0, 10'd0);
        n_tests++;
        if (valid !== 1'b1 || avg !== 10'd0 || empty !== 1'b1 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_valid: valid=%b avg=%0d empty=%b full=%b required 1,0,1,1",
                     valid, avg, empty, full);
        end
        for (int k = 0; k < 8; k++) begin
            sensor = (k < 4) ? 10'd25 : 10'd40;
            tick_update();
            n_tests++;
            if (avg !== 10'(ea[k]) || empty !== ee[k] || full !== 1'b1) begin
                n_fail++;
                $display("FAIL empty_%0d: avg=%0d empty=%b full=%b required %0d,%b,1",
                         k, avg, empty, full, ea[k], ee[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int k;
        fill(10'd300, 10'd300);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({tick, avg, valid, full, empty, delta, spikes} !== 34'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h required 0",
                     {tick, avg, valid, full, empty, delta, spikes});
        end
        reset = 1'b0;
        k = 1;
        while (tick !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k != 5) begin
            n_fail++;
            $display("FAIL midrun_first_tick: tick in cycle %0d required 5", k);
        end
        @(negedge clk);
        repeat (2) tick_update();
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_prevalid: valid=%b required 0", valid);
        end
        tick_update();
        n_tests++;
        if (valid !== 1'b1 || avg !== 10'd300) begin
            n_fail++;
            $display("FAIL midrun_valid: valid=%b avg=%0d required 1,300", valid, avg);
        end
    endtask

    task automatic test_spike();
        fill(10'd300, 10'd300);
        sensor = 10'd500;
        tick_update();
`ifdef WATER_LEVEL_SPIKE_REJECT_EN
        n_tests++;
        if (avg !== 10'd300 || spikes !== 8'd1 || delta !== 11'sd0) begin
            n_fail++;
            $display("FAIL spike_single: avg=%0d spikes=%0d delta=%0d required 300,1,0", avg, spikes, delta);
        end
        sensor = 10'd300;
        tick_update();
        for (int k = 1; k <= 3; k++) begin
            sensor = 10'd500;
            tick_update();
            n_tests++;
            if (avg !== ((k == 3) ? 10'd350 : 10'd300) || spikes !== 8'(1 + ((k < 3) ? k : 2))) begin
                n_fail++;
                $display("FAIL spike_run_%0d: avg=%0d spikes=%0d required %0d,%0d",
                         k, avg, spikes, (k == 3) ? 350 : 300, 1 + ((k < 3) ? k : 2));
            end
        end
        n_tests++;
        if (delta !== 11'sd50) begin
            n_fail++;
            $display("FAIL spike_step_delta: got %0d required 50", delta);
        end
`else
        n_tests++;
        if (avg !== 10'd350 || delta !== 11'sd50 || spikes !== 8'd0) begin
            n_fail++;
            $display("FAIL spike_accept: avg=%0d delta=%0d spikes=%0d required 350,50,0", avg, delta, spikes);
        end
`endif
    endtask

    initial begin
        reset  = 1'b1;
        sensor = 10'd0;
        target = 10'd0;
        test_reset();
        test_fill_300();
        test_full_hyst();
        test_empty();
        test_mid_reset();
        test_spike();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
